// File: rtl/decode_pkg.sv
// +----------------------------------------------------------------------------+
// | decode_pkg                                                                 |
// | Shared types and encodings for the RV32I decode stage (ADDI/ADD/BEQ/JAL).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package decode_pkg;

   localparam int DEC_DATA_WIDTH = 32;
   localparam int DEC_DIR_WIDTH  = 5;

   typedef enum logic [2:0] {
      OP_ADDI    = 3'd0,
      OP_ADD     = 3'd1,
      OP_BEQ     = 3'd2,
      OP_JAL     = 3'd3,
      OP_ILLEGAL = 3'd4
   } op_t;

   localparam int NUM_OPS = 5;

   localparam logic [6:0] OPC_ADDI = 7'b0010011;
   localparam logic [6:0] OPC_ADD  = 7'b0110011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;

   localparam logic [2:0] FUNCT3_ZERO = 3'b000;
   localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;

   typedef struct packed {
      op_t                       op;
      logic [DEC_DIR_WIDTH-1:0]  rd;
      logic [DEC_DIR_WIDTH-1:0]  rs1;
      logic [DEC_DIR_WIDTH-1:0]  rs2;
      logic [DEC_DATA_WIDTH-1:0] imm;
      logic [DEC_DATA_WIDTH-1:0] pc;
      logic                      reg_write;
   } decoded_t;

   // Ops whose result lands in rd; BEQ and illegal never write back.
   function automatic logic op_writes_rd(input op_t op);
      return (op == OP_ADDI) || (op == OP_ADD) || (op == OP_JAL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// +----------------------------------------------------------------------------+
// | instr_decoder                                                              |
// | Combinational RV32I subset decoder: instruction + pc -> decoded_t.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module instr_decoder
   import decode_pkg::*;
(
   input  logic [DEC_DATA_WIDTH-1:0] instr,
   input  logic [DEC_DATA_WIDTH-1:0] pc,
   output decoded_t                  dec
);

   logic [6:0]               w_opcode;
   logic [2:0]               w_funct3;
   logic [6:0]               w_funct7;
   logic [DEC_DIR_WIDTH-1:0] w_rd;
   logic [DEC_DIR_WIDTH-1:0] w_rs1;
   logic [DEC_DIR_WIDTH-1:0] w_rs2;

   assign w_opcode = instr[6:0];
   assign w_rd     = instr[11:7];
   assign w_funct3 = instr[14:12];
   assign w_rs1    = instr[19:15];
   assign w_rs2    = instr[24:20];
   assign w_funct7 = instr[31:25];

   // Illegal is the default so that any unmatched encoding yields zeroed fields.
   always_comb begin
      dec     = '0;
      dec.op  = OP_ILLEGAL;
      dec.pc  = pc;
      case (w_opcode)
         OPC_ADDI: begin
            if (w_funct3 == FUNCT3_ZERO) begin
               dec.op  = OP_ADDI;
               dec.rd  = w_rd;
               dec.rs1 = w_rs1;
               dec.imm = {{20{instr[31]}}, instr[31:20]};
            end
         end
         OPC_ADD: begin
            if ((w_funct3 == FUNCT3_ZERO) && (w_funct7 == FUNCT7_ZERO)) begin
               dec.op  = OP_ADD;
               dec.rd  = w_rd;
               dec.rs1 = w_rs1;
               dec.rs2 = w_rs2;
            end
         end
         OPC_BEQ: begin
            if (w_funct3 == FUNCT3_ZERO) begin
               dec.op  = OP_BEQ;
               dec.rs1 = w_rs1;
               dec.rs2 = w_rs2;
               dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            end
         end
         OPC_JAL: begin
            dec.op  = OP_JAL;
            dec.rd  = w_rd;
            dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
         end
         default: begin
            dec.op = OP_ILLEGAL;
         end
      endcase
      dec.reg_write = op_writes_rd(dec.op) && (dec.rd != '0);
   end

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// +----------------------------------------------------------------------------+
// | instr_decode_stage                                                         |
// | Decode stage with OUT/SKID 2-entry skid buffer; optional per-op transfer   |
// | counters enabled by defining DECODE_STATS_EN.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIR_WIDTH  = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_instr,
   input  logic [DATA_WIDTH-1:0] in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output op_t                   out_op,
   output logic [DIR_WIDTH-1:0]  out_rd,
   output logic [DIR_WIDTH-1:0]  out_rs1,
   output logic [DIR_WIDTH-1:0]  out_rs2,
   output logic [DATA_WIDTH-1:0] out_imm,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic                  out_reg_write,
   output logic                  out_illegal
`ifdef DECODE_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]  cnt_addi,
   output logic [CNT_WIDTH-1:0]  cnt_add,
   output logic [CNT_WIDTH-1:0]  cnt_beq,
   output logic [CNT_WIDTH-1:0]  cnt_jal,
   output logic [CNT_WIDTH-1:0]  cnt_illegal
`endif
);

   // The decoded_t layout is fixed by the package; other widths are rejected.
   if ((DATA_WIDTH != DEC_DATA_WIDTH) || (DIR_WIDTH != DEC_DIR_WIDTH) ||
       (CNT_WIDTH < 1)) begin : g_param_check
      $error("instr_decode_stage: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t   r_state;
   decoded_t r_out;
   decoded_t r_skid;
   logic     r_in_ready;
   logic     r_out_valid;

   decoded_t w_dec;
   logic     w_accept;
   logic     w_drain;

   instr_decoder u_decoder (
      .instr (in_instr),
      .pc    (in_pc),
      .dec   (w_dec)
   );

   assign w_accept = in_valid && r_in_ready;
   assign w_drain  = r_out_valid && out_ready;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state     <= ST_EMPTY;
         r_out       <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_state     <= ST_EMPTY;
         r_out       <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_out       <= w_dec;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  r_out <= w_dec;
               end else if (w_accept) begin
                  r_skid     <= w_dec;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_FULL;
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a drain can move the state.
               if (w_drain) begin
                  r_out      <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign out_op        = r_out.op;
   assign out_rd        = r_out.rd;
   assign out_rs1       = r_out.rs1;
   assign out_rs2       = r_out.rs2;
   assign out_imm       = r_out.imm;
   assign out_pc        = r_out.pc;
   assign out_reg_write = r_out.reg_write;
   assign out_illegal   = (r_out.op == OP_ILLEGAL);

`ifdef DECODE_STATS_EN
   logic [CNT_WIDTH-1:0] r_cnt [NUM_OPS];

   // Counters survive flush; only arst clears them. They stick at all-ones.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (w_drain && !flush) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if ((r_out.op == op_t'(i)) && (r_cnt[i] != '1)) begin
               r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign cnt_addi    = r_cnt[OP_ADDI];
   assign cnt_add     = r_cnt[OP_ADD];
   assign cnt_beq     = r_cnt[OP_BEQ];
   assign cnt_jal     = r_cnt[OP_JAL];
   assign cnt_illegal = r_cnt[OP_ILLEGAL];
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// +----------------------------------------------------------------------------+
// | tb_instr_decode_stage                                                      |
// | Directed + random bench for instr_decode_stage against a queue model.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_decode_stage;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        arst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   op_t         out_op;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [31:0] out_imm;
   logic [31:0] out_pc;
   logic        out_reg_write;
   logic        out_illegal;
`ifdef DECODE_STATS_EN
   logic [15:0] cnt_addi;
   logic [15:0] cnt_add;
   logic [15:0] cnt_beq;
   logic [15:0] cnt_jal;
   logic [15:0] cnt_illegal;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_decode_stage #(
      .DATA_WIDTH (32),
      .DIR_WIDTH  (5),
      .CNT_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .arst          (arst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_op        (out_op),
      .out_rd        (out_rd),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_imm       (out_imm),
      .out_pc        (out_pc),
      .out_reg_write (out_reg_write),
      .out_illegal   (out_illegal)
`ifdef DECODE_STATS_EN
      ,
      .cnt_addi      (cnt_addi),
      .cnt_add       (cnt_add),
      .cnt_beq       (cnt_beq),
      .cnt_jal       (cnt_jal),
      .cnt_illegal   (cnt_illegal)
`endif
   );

   typedef struct {
      op_t         op;
      int          rd;
      int          rs1;
      int          rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      bit          wr;
   } exp_t;

   exp_t q[$];
   int   cnt_m[5];

   // Reference decode from the ISA field rules, using integer arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      int opc, f3, f7, rd, rs1, rs2, off;
      opc = int'(ins & 32'h7f);
      rd  = int'((ins >> 7) & 32'd31);
      f3  = int'((ins >> 12) & 32'd7);
      rs1 = int'((ins >> 15) & 32'd31);
      rs2 = int'((ins >> 20) & 32'd31);
      f7  = int'(ins >> 25);
      e.op = OP_ILLEGAL; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0; e.pc = pc; e.wr = 0;
      if (opc == 'h13 && f3 == 0) begin
         e.op = OP_ADDI; e.rd = rd; e.rs1 = rs1;
         e.imm = 32'($signed(ins) >>> 20);
      end else if (opc == 'h33 && f3 == 0 && f7 == 0) begin
         e.op = OP_ADD; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      end else if (opc == 'h63 && f3 == 0) begin
         off = int'((ins >> 8) & 32'd15) * 2 + int'((ins >> 25) & 32'd63) * 32
             + int'((ins >> 7) & 32'd1) * 2048 - int'(ins >> 31) * 4096;
         e.op = OP_BEQ; e.rs1 = rs1; e.rs2 = rs2; e.imm = 32'(off);
      end else if (opc == 'h6f) begin
         off = int'((ins >> 21) & 32'd1023) * 2 + int'((ins >> 20) & 32'd1) * 2048
             + int'((ins >> 12) & 32'd255) * 4096 - int'(ins >> 31) * (1 << 20);
         e.op = OP_JAL; e.rd = rd; e.imm = 32'(off);
      end
      e.wr = (e.op == OP_ADDI || e.op == OP_ADD || e.op == OP_JAL) && (e.rd != 0);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0:       return {r[31:15], 3'b000, r[11:7], 7'h13};
         1:       return {7'h00, r[24:15], 3'b000, r[11:7], 7'h33};
         2:       return {r[31:15], 3'b000, r[11:7], 7'h63};
         3:       return {r[31:7], 7'h6f};
         4:       return {7'h20, r[24:15], 3'b000, r[11:7], 7'h33};
         5:       return {r[31:15], (r[14:12] | 3'b001), r[11:7], 7'h63};
         default: return r;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         check({tag, ".op"}, 32'(out_op), 32'(q[0].op));
         check({tag, ".rd"}, 32'(out_rd), 32'(q[0].rd));
         check({tag, ".rs1"}, 32'(out_rs1), 32'(q[0].rs1));
         check({tag, ".rs2"}, 32'(out_rs2), 32'(q[0].rs2));
         check({tag, ".imm"}, out_imm, q[0].imm);
         check({tag, ".pc"}, out_pc, q[0].pc);
         check({tag, ".reg_write"}, 32'(out_reg_write), 32'(q[0].wr));
         check({tag, ".illegal"}, 32'(out_illegal), 32'(q[0].op == OP_ILLEGAL));
      end
`ifdef DECODE_STATS_EN
      check({tag, ".cnt_addi"}, 32'(cnt_addi), 32'(cnt_m[0]));
      check({tag, ".cnt_add"}, 32'(cnt_add), 32'(cnt_m[1]));
      check({tag, ".cnt_beq"}, 32'(cnt_beq), 32'(cnt_m[2]));
      check({tag, ".cnt_jal"}, 32'(cnt_jal), 32'(cnt_m[3]));
      check({tag, ".cnt_illegal"}, 32'(cnt_illegal), 32'(cnt_m[4]));
`endif
   endtask

   task automatic expect_out(input string tag, input op_t op, input int rd, input int rs1,
                             input int rs2, input logic [31:0] imm, input logic [31:0] pc,
                             input bit wr);
      check({tag, ".k_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".k_op"}, 32'(out_op), 32'(op));
      check({tag, ".k_rd"}, 32'(out_rd), 32'(rd));
      check({tag, ".k_rs1"}, 32'(out_rs1), 32'(rs1));
      check({tag, ".k_rs2"}, 32'(out_rs2), 32'(rs2));
      check({tag, ".k_imm"}, out_imm, imm);
      check({tag, ".k_pc"}, out_pc, pc);
      check({tag, ".k_wr"}, 32'(out_reg_write), 32'(wr));
      check({tag, ".k_illegal"}, 32'(out_illegal), 32'(op == OP_ILLEGAL));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".op"}, 32'(out_op), 32'd0);
      check({tag, ".fields"}, {17'd0, out_rd, out_rs1, out_rs2}, 32'd0);
      check({tag, ".imm"}, out_imm, 32'd0);
      check({tag, ".pc"}, out_pc, 32'd0);
      check({tag, ".wr_ill"}, {30'd0, out_reg_write, out_illegal}, 32'd0);
   endtask

   // Drive one cycle from a negedge, advance the model, return at the next negedge.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, output bit taken);
      bit acc, drn;
      int k;
      acc   = v && (q.size() < 2);
      drn   = ordy && (q.size() > 0);
      taken = v && (fl || acc);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      if (fl) begin
         q.delete();
      end else begin
         if (drn) begin
            k = int'(q[0].op);
            if (cnt_m[k] < 65535) cnt_m[k]++;
            void'(q.pop_front());
         end
         if (acc) q.push_back(ref_decode(ins, pc));
      end
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 5; i++) cnt_m[i] = 0;
   endtask

   initial begin
      bit          tk;
      bit          hv;
      logic [31:0] hins;
      logic [31:0] hpc;

      arst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      model_reset();
      #2;
      check_zero_outputs("reset");
      repeat (2) @(negedge clk);
      arst = 1'b0;
      check_outputs("idle");

      // Directed decode of each supported encoding, streaming with out_ready high.
      step(1, 32'hFFF08293, 32'h100, 1, 0, tk);
      check_outputs("addi");
      expect_out("addi", OP_ADDI, 5, 1, 0, 32'hFFFFFFFF, 32'h100, 1);
      step(1, 32'h002081B3, 32'h104, 1, 0, tk);
      check_outputs("add");
      expect_out("add", OP_ADD, 3, 1, 2, 32'h0, 32'h104, 1);
      step(1, 32'hFE208CE3, 32'h108, 1, 0, tk);
      check_outputs("beq");
      expect_out("beq", OP_BEQ, 0, 1, 2, 32'hFFFFFFF8, 32'h108, 0);
      step(1, 32'h010000EF, 32'h10C, 1, 0, tk);
      check_outputs("jal");
      expect_out("jal", OP_JAL, 1, 0, 0, 32'h00000010, 32'h10C, 1);
      step(1, 32'h00000000, 32'h110, 1, 0, tk);
      check_outputs("ill0");
      expect_out("ill0", OP_ILLEGAL, 0, 0, 0, 32'h0, 32'h110, 0);
      step(1, 32'h402081B3, 32'h114, 1, 0, tk);
      check_outputs("ill1");
      expect_out("ill1", OP_ILLEGAL, 0, 0, 0, 32'h0, 32'h114, 0);
      step(0, 32'h0, 32'h0, 1, 0, tk);
      check_outputs("drain");
`ifdef DECODE_STATS_EN
      check("stats.illegal2", 32'(cnt_illegal), 32'd2);
`endif

      // Backpressure: two accepted, third held by fetch until space frees.
      step(1, 32'h00108093, 32'h200, 0, 0, tk);
      check_outputs("bp1");
      step(1, 32'h00208133, 32'h204, 0, 0, tk);
      check_outputs("bp2");
      check("bp.in_ready_low", 32'(in_ready), 32'd0);
      step(1, 32'h008001EF, 32'h208, 0, 0, tk);
      check_outputs("bp3");
      check("bp.third_held", 32'(tk), 32'd0);
      step(1, 32'h008001EF, 32'h208, 1, 0, tk);
      check_outputs("bp_drainA");
      expect_out("bp_B", OP_ADD, 2, 1, 2, 32'h0, 32'h204, 1);
      step(1, 32'h008001EF, 32'h208, 1, 0, tk);
      check_outputs("bp_drainB");
      expect_out("bp_C", OP_JAL, 3, 0, 0, 32'h8, 32'h208, 1);
      step(0, 32'h0, 32'h0, 1, 0, tk);
      check_outputs("bp_drainC");

      // Flush while FULL, with a new instruction offered in the same cycle.
      step(1, 32'h00108093, 32'h300, 0, 0, tk);
      step(1, 32'h00208133, 32'h304, 0, 0, tk);
      check_outputs("fl_full");
      step(1, 32'h008001EF, 32'h308, 1, 1, tk);
      check("flush.out_valid", 32'(out_valid), 32'd0);
      check("flush.in_ready", 32'(in_ready), 32'd1);
      step(0, 32'h0, 32'h0, 1, 0, tk);
      check_outputs("fl_after");

      // Asynchronous reset in the middle of a cycle while FULL.
      step(1, 32'h00108093, 32'h400, 0, 0, tk);
      step(1, 32'h00208133, 32'h404, 0, 0, tk);
      check_outputs("rst_full");
      in_valid = 1'b0;
      #2;
      arst = 1'b1;
      model_reset();
      #1;
      check_zero_outputs("midrst");
      @(negedge clk);
      arst = 1'b0;
      check_outputs("midrst_rel");

      // Random traffic with fetch holding each instruction until it is taken.
      hv = 0; hins = '0; hpc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         if (!hv) begin
            hv   = ($urandom_range(0, 3) != 0);
            hins = rand_instr();
            hpc  = hpc + 32'd4;
         end
         step(hv, hins, hpc, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, tk);
         if (tk) hv = 0;
         check_outputs("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
